// File: rtl/mem_access_pkg.sv
// Shared op codes, FSM state encoding and byte-lane helpers for the data-memory stage.
// Latency: n/a (declarations and pure combinational functions only).
// Backpressure: n/a.
package mem_access_pkg;

  // Memory op codes as presented by the EX stage; codes 11..15 behave as OP_NONE
  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_LB   = 4'd1,
    OP_LBU  = 4'd2,
    OP_LH   = 4'd3,
    OP_LHU  = 4'd4,
    OP_LW   = 4'd5,
    OP_SB   = 4'd6,
    OP_SH   = 4'd7,
    OP_SW   = 4'd8,
    OP_LL   = 4'd9,
    OP_SC   = 4'd10
  } op_e;

  // Access FSM: DRAIN finishes a bus cycle whose result has been flushed away
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Request captured when an op is accepted; held stable for the whole bus cycle
  typedef struct packed {
    logic [3:0]  op;
    logic [29:0] word_addr;
    logic [1:0]  byte_off;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        wr;
    logic        adel;
    logic        ades;
    logic        sc_ok;
  } req_t;

  function automatic logic op_is_mem(input logic [3:0] op);
    return (op >= OP_LB) && (op <= OP_SC);
  endfunction

  function automatic logic op_is_store(input logic [3:0] op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW) || (op == OP_SC);
  endfunction

  function automatic logic op_is_byte(input logic [3:0] op);
    return (op == OP_LB) || (op == OP_LBU) || (op == OP_SB);
  endfunction

  function automatic logic op_is_half(input logic [3:0] op);
    return (op == OP_LH) || (op == OP_LHU) || (op == OP_SH);
  endfunction

  // Bytes never fault; halves need bit 0 clear; words, LL and SC need both bits clear
  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] off);
    if (op_is_byte(op))      return 1'b0;
    else if (op_is_half(op)) return off[0];
    else                     return |off;
  endfunction

  // Little-endian lane enables for an aligned access
  function automatic logic [3:0] op_byte_en(input logic [3:0] op, input logic [1:0] off);
    if (op_is_byte(op))      return 4'b0001 << off;
    else if (op_is_half(op)) return off[1] ? 4'b1100 : 4'b0011;
    else                     return 4'b1111;
  endfunction

  // Store data replicated across every lane so the byte enables alone pick the target
  function automatic logic [31:0] op_store_data(input logic [3:0] op, input logic [31:0] wdata);
    if (!op_is_store(op))    return 32'h0;
    else if (op_is_byte(op)) return {4{wdata[7:0]}};
    else if (op_is_half(op)) return {2{wdata[15:0]}};
    else                     return wdata;
  endfunction

endpackage

// File: rtl/mem_access_load_align.sv
// Selects the addressed byte/half-word lane of a read word and sign/zero extends it.
// Latency: purely combinational.
// Backpressure: none.
module load_align
  import mem_access_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [1:0]  byte_off,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  // Pick the lane addressed by the low address bits
  always_comb begin
    byte_lane = rdata[7:0];
    case (byte_off)
      2'd0: byte_lane = rdata[7:0];
      2'd1: byte_lane = rdata[15:8];
      2'd2: byte_lane = rdata[23:16];
      2'd3: byte_lane = rdata[31:24];
      default: byte_lane = rdata[7:0];
    endcase
    half_lane = byte_off[1] ? rdata[31:16] : rdata[15:0];
  end

  // Extend the lane to 32 bits; word loads and LL pass the word through
  always_comb begin
    data = rdata;
    case (op)
      OP_LB:   data = {{24{byte_lane[7]}}, byte_lane};
      OP_LBU:  data = {24'h0, byte_lane};
      OP_LH:   data = {{16{half_lane[15]}}, half_lane};
      OP_LHU:  data = {16'h0, half_lane};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// MEM stage: issues loads/stores/LL/SC on a single-outstanding data bus, aligns load data.
// Latency: accept cycle + bus wait cycles + one DONE cycle; faults and failed SC take 2 cycles.
// Backpressure: stall_o holds upstream from acceptance until the cycle before DONE; bus via mem_ack_i.
module mem_access
  import mem_access_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        valid_i,
  input  logic [3:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic        llbit_i,
  input  logic        wb_llbit_we_i,
  input  logic        wb_llbit_i,
  output logic        mem_req_o,
  output logic        mem_wr_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        adel_o,
  output logic        ades_o,
  output logic        llbit_we_o,
  output logic        llbit_o
);

  state_e      state_q, state_d;
  req_t        req_q, new_req;
  logic [31:0] rdata_q;
  logic [31:0] load_data;

  logic eff_llbit;
  logic accept;
  logic misaligned;
  logic sc_fail;
  logic err_q;

  // LLbit as seen by this op: a write still sitting in WB takes priority over the register
  assign eff_llbit  = wb_llbit_we_i ? wb_llbit_i : llbit_i;
  assign accept     = valid_i && op_is_mem(op_i) && !flush;
  assign misaligned = op_misaligned(op_i, addr_i[1:0]);
  assign sc_fail    = (op_i == OP_SC) && !eff_llbit;
  assign err_q      = req_q.adel || req_q.ades;

  // Build the request snapshot taken on acceptance
  always_comb begin
    new_req           = '0;
    new_req.op        = op_i;
    new_req.word_addr = addr_i[31:2];
    new_req.byte_off  = addr_i[1:0];
    new_req.wdata     = op_store_data(op_i, wdata_i);
    new_req.be        = op_byte_en(op_i, addr_i[1:0]);
    new_req.wr        = op_is_store(op_i);
    new_req.adel      = misaligned && !op_is_store(op_i);
    new_req.ades      = misaligned && op_is_store(op_i);
    new_req.sc_ok     = (op_i == OP_SC) && !misaligned && eff_llbit;
  end

  // State register; reset wins over flush and ack
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (misaligned || sc_fail) state_d = ST_DONE;
          else                       state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (mem_ack_i)  state_d = flush ? ST_IDLE : ST_DONE;
        else if (flush) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (mem_ack_i) state_d = ST_IDLE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Request snapshot on accept, read data on the completing ack
  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      rdata_q <= 32'h0;
    end else begin
      if (state_q == ST_IDLE && accept) req_q <= new_req;
      if (state_q == ST_WAIT && mem_ack_i) rdata_q <= mem_rdata_i;
    end
  end

  load_align u_load_align (
    .op       (req_q.op),
    .byte_off (req_q.byte_off),
    .rdata    (rdata_q),
    .data     (load_data)
  );

  // Outputs per state; everything is forced low while rst is high
  always_comb begin
    mem_req_o   = 1'b0;
    mem_wr_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_addr_o  = 32'h0;
    mem_wdata_o = 32'h0;
    stall_o     = 1'b0;
    done_o      = 1'b0;
    result_o    = 32'h0;
    adel_o      = 1'b0;
    ades_o      = 1'b0;
    llbit_we_o  = 1'b0;
    llbit_o     = 1'b0;
    if (!rst) begin
      case (state_q)
        ST_IDLE: stall_o = accept;
        ST_WAIT, ST_DRAIN: begin
          mem_req_o   = 1'b1;
          mem_wr_o    = req_q.wr;
          mem_be_o    = req_q.be;
          mem_addr_o  = {req_q.word_addr, 2'b00};
          mem_wdata_o = req_q.wdata;
          stall_o     = 1'b1;
        end
        ST_DONE: begin
          if (!flush) begin
            done_o = 1'b1;
            adel_o = req_q.adel;
            ades_o = req_q.ades;
            if (req_q.op == OP_SC)
              result_o = {31'h0, req_q.sc_ok};
            else if (!err_q && !op_is_store(req_q.op))
              result_o = load_data;
            // A faulting LL never reached the bus, so it must not arm the link
            llbit_we_o = ((req_q.op == OP_LL) && !err_q) || req_q.sc_ok;
            llbit_o    = (req_q.op == OP_LL) && !err_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
module tb_mem_access;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        valid_i = 1'b0;
  logic [3:0]  op_i = 4'd0;
  logic [31:0] addr_i = 32'h0;
  logic [31:0] wdata_i = 32'h0;
  logic        llbit_i = 1'b0;
  logic        wb_llbit_we_i = 1'b0;
  logic        wb_llbit_i = 1'b0;
  logic        mem_req_o, mem_wr_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'h0;
  logic        stall_o, done_o;
  logic [31:0] result_o;
  logic        adel_o, ades_o, llbit_we_o, llbit_o;
  logic [107:0] all_out;

  int total = 0;
  int bad = 0;
  logic llreg = 1'b0;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        llbit;
    logic        wb_we;
    logic        wb_ll;
    int          lat;
    int          flush_at;
  } stim_t;

  typedef struct {
    int          req_cnt;
    int          done_cnt;
    logic        stall0;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] result;
    logic        adel;
    logic        ades;
    logic        llwe;
    logic        llv;
  } exp_t;

  typedef struct {
    int          req_cnt;
    int          done_cnt;
    int          stall_bad;
    int          unstable;
    logic        stall0;
    logic        wr;
    logic [3:0]  be;
    logic [31:0] maddr;
    logic [31:0] mwdata;
    logic [31:0] result;
    logic        adel;
    logic        ades;
    logic        llwe;
    logic        llv;
  } obs_t;

  mem_access dut (
    .clk(clk), .rst(rst), .flush(flush), .valid_i(valid_i), .op_i(op_i),
    .addr_i(addr_i), .wdata_i(wdata_i), .llbit_i(llbit_i),
    .wb_llbit_we_i(wb_llbit_we_i), .wb_llbit_i(wb_llbit_i),
    .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
    .stall_o(stall_o), .done_o(done_o), .result_o(result_o),
    .adel_o(adel_o), .ades_o(ades_o), .llbit_we_o(llbit_we_o), .llbit_o(llbit_o)
  );

  assign all_out = {mem_req_o, mem_wr_o, mem_be_o, mem_addr_o, mem_wdata_o, stall_o,
                    done_o, result_o, adel_o, ades_o, llbit_we_o, llbit_o};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference behaviour from the architectural rules: sizes, offsets, lane arithmetic
  function automatic exp_t model(input stim_t s);
    exp_t   e;
    int     size, off;
    bit     store, eff;
    longint mask, lane;
    e = '{default: 0};
    if (!(s.op >= 4'd1 && s.op <= 4'd10)) return e;
    store = (s.op == 4'd6) || (s.op == 4'd7) || (s.op == 4'd8) || (s.op == 4'd10);
    if (s.op == 4'd1 || s.op == 4'd2 || s.op == 4'd6)      size = 1;
    else if (s.op == 4'd3 || s.op == 4'd4 || s.op == 4'd7) size = 2;
    else                                                   size = 4;
    off = int'(s.addr % 32'd4);
    eff = s.wb_we ? s.wb_ll : s.llbit;
    e.stall0 = 1'b1;
    e.done_cnt = 1;
    if (off % size != 0) begin
      e.adel = !store;
      e.ades = store;
      return e;
    end
    if (s.op == 4'd10 && !eff) return e;
    e.req_cnt = s.lat;
    e.wr = store;
    e.maddr = s.addr - 32'(off);
    e.be = 4'(((1 << size) - 1) << off);
    mask = (64'd1 << (8 * size)) - 1;
    if (store)
      for (int i = 0; i < 4 / size; i++)
        e.mwdata = e.mwdata | 32'((longint'(s.wdata) & mask) << (8 * size * i));
    if (s.flush_at >= 1 && s.flush_at <= s.lat) begin
      e.done_cnt = 0;
      return e;
    end
    if (!store) begin
      lane = (longint'(s.rdata) >> (8 * off)) & mask;
      if ((s.op == 4'd1 || s.op == 4'd3) && lane > mask / 2) lane = lane - (mask + 1);
      e.result = 32'(lane);
    end
    if (s.op == 4'd9) begin e.llwe = 1'b1; e.llv = 1'b1; end
    if (s.op == 4'd10) begin e.result = 32'd1; e.llwe = 1'b1; e.llv = 1'b0; end
    return e;
  endfunction

  // Present one op, act as bus slave (ack after s.lat request cycles), optional WAIT flush
  task automatic run_op(input stim_t s, output obs_t o);
    int   wait_cnt;
    logic req, stl, dn;
    o = '{default: 0};
    @(negedge clk);
    valid_i = 1'b1; op_i = s.op; addr_i = s.addr; wdata_i = s.wdata;
    llbit_i = s.llbit; wb_llbit_we_i = s.wb_we; wb_llbit_i = s.wb_ll;
    mem_rdata_i = s.rdata; mem_ack_i = 1'b0; flush = 1'b0;
    #1 o.stall0 = stall_o;
    wait_cnt = 0;
    for (int c = 0; c < s.lat + 6; c++) begin
      @(negedge clk);
      req = mem_req_o; stl = stall_o; dn = done_o;
      if (req) begin
        wait_cnt++;
        o.req_cnt = wait_cnt;
        if (wait_cnt == 1) begin
          o.wr = mem_wr_o; o.be = mem_be_o; o.maddr = mem_addr_o; o.mwdata = mem_wdata_o;
        end else if ({mem_wr_o, mem_be_o, mem_addr_o, mem_wdata_o} !== {o.wr, o.be, o.maddr, o.mwdata}) begin
          o.unstable++;
        end
      end
      if (stl !== req) o.stall_bad++;
      if (dn) begin
        o.done_cnt++;
        o.result = result_o; o.adel = adel_o; o.ades = ades_o;
        o.llwe = llbit_we_o; o.llv = llbit_o;
      end
      flush = 1'b0;
      mem_ack_i = req && (wait_cnt == s.lat);
      if (req && wait_cnt == s.flush_at) begin flush = 1'b1; valid_i = 1'b0; end
      if (!stl) valid_i = 1'b0;
    end
    valid_i = 1'b0; mem_ack_i = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; valid_i = 1'b1; op_i = 4'd5; addr_i = 32'h100; flush = 1'b1; mem_ack_i = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL reset_during outputs got=%h want=0", all_out); end
    rst = 1'b0; valid_i = 1'b0; flush = 1'b0; mem_ack_i = 1'b0;
    @(negedge clk);
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL reset_after outputs got=%h want=0", all_out); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    valid_i = 1'b1; op_i = 4'd5; addr_i = 32'h40;
    repeat (2) @(negedge clk);
    total++;
    if (mem_req_o !== 1'b1) begin bad++; $display("FAIL rst_mid_req got=%b want=1", mem_req_o); end
    rst = 1'b1; mem_ack_i = 1'b1; flush = 1'b1;
    #1;
    total++;
    if (all_out !== '0) begin bad++; $display("FAIL rst_mid_during got=%h want=0", all_out); end
    @(negedge clk);
    rst = 1'b0; mem_ack_i = 1'b0; flush = 1'b0; valid_i = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if ({mem_req_o, done_o, stall_o} !== 3'b000) begin
      bad++; $display("FAIL rst_mid_after req/done/stall got=%b want=000", {mem_req_o, done_o, stall_o});
    end
  endtask

  task automatic test_directed();
    stim_t s; exp_t e; obs_t o;
    for (int i = 0; i < 13; i++) begin
      case (i)
        0:  begin s = '{4'd5, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 3, 0};
                  e = '{3, 1, 1'b1, 1'b0, 4'hF, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0, 1'b0}; end
        1:  begin s = '{4'd1, 32'h103, 32'h0, 32'h80000000, 1'b0, 1'b0, 1'b0, 1, 0};
                  e = '{1, 1, 1'b1, 1'b0, 4'h8, 32'h100, 32'h0, 32'hFFFFFF80, 1'b0, 1'b0, 1'b0, 1'b0}; end
        2:  begin s = '{4'd2, 32'h103, 32'h0, 32'h80000000, 1'b0, 1'b0, 1'b0, 1, 0};
                  e = '{1, 1, 1'b1, 1'b0, 4'h8, 32'h100, 32'h0, 32'h00000080, 1'b0, 1'b0, 1'b0, 1'b0}; end
        3:  begin s = '{4'd9, 32'h200, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b0, 2, 0};
                  e = '{2, 1, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 32'h12345678, 1'b0, 1'b0, 1'b1, 1'b1}; end
        4:  begin s = '{4'd10, 32'h200, 32'h5, 32'h0, 1'b1, 1'b0, 1'b0, 1, 0};
                  e = '{1, 1, 1'b1, 1'b1, 4'hF, 32'h200, 32'h5, 32'h1, 1'b0, 1'b0, 1'b1, 1'b0}; end
        5:  begin s = '{4'd10, 32'h200, 32'h5, 32'h0, 1'b1, 1'b1, 1'b0, 1, 0};
                  e = '{0, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0}; end
        6:  begin s = '{4'd7, 32'h101, 32'h1234, 32'h0, 1'b0, 1'b0, 1'b0, 1, 0};
                  e = '{0, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0}; end
        7:  begin s = '{4'd5, 32'h102, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1, 0};
                  e = '{0, 1, 1'b1, 1'b0, 4'h0, 32'h0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0}; end
        8:  begin s = '{4'd6, 32'h102, 32'h123456AB, 32'h0, 1'b0, 1'b0, 1'b0, 2, 0};
                  e = '{2, 1, 1'b1, 1'b1, 4'h4, 32'h100, 32'hABABABAB, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0}; end
        9:  begin s = '{4'd3, 32'h102, 32'h0, 32'h80010000, 1'b0, 1'b0, 1'b0, 1, 0};
                  e = '{1, 1, 1'b1, 1'b0, 4'hC, 32'h100, 32'h0, 32'hFFFF8001, 1'b0, 1'b0, 1'b0, 1'b0}; end
        10: begin s = '{4'd4, 32'h100, 32'h0, 32'h1234F00D, 1'b0, 1'b0, 1'b0, 2, 0};
                  e = '{2, 1, 1'b1, 1'b0, 4'h3, 32'h100, 32'h0, 32'h0000F00D, 1'b0, 1'b0, 1'b0, 1'b0}; end
        11: begin s = '{4'd0, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1, 0};
                  e = '{default: 0}; end
        default: begin s = '{4'd13, 32'h100, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1, 0};
                  e = '{default: 0}; end
      endcase
      run_op(s, o);
      total++; if (o.req_cnt !== e.req_cnt) begin bad++; $display("FAIL dir%0d req_cycles got=%0d want=%0d", i, o.req_cnt, e.req_cnt); end
      total++; if (o.done_cnt !== e.done_cnt) begin bad++; $display("FAIL dir%0d done_count got=%0d want=%0d", i, o.done_cnt, e.done_cnt); end
      total++; if (o.stall0 !== e.stall0) begin bad++; $display("FAIL dir%0d accept_stall got=%b want=%b", i, o.stall0, e.stall0); end
      total++; if (o.stall_bad != 0) begin bad++; $display("FAIL dir%0d stall_profile bad_cycles=%0d want=0", i, o.stall_bad); end
      total++; if (o.unstable != 0) begin bad++; $display("FAIL dir%0d bus_stable changes=%0d want=0", i, o.unstable); end
      total++; if (o.result !== e.result) begin bad++; $display("FAIL dir%0d result got=%h want=%h", i, o.result, e.result); end
      total++; if ({o.adel, o.ades} !== {e.adel, e.ades}) begin bad++; $display("FAIL dir%0d adel/ades got=%b%b want=%b%b", i, o.adel, o.ades, e.adel, e.ades); end
      total++; if ({o.llwe, o.llv} !== {e.llwe, e.llv}) begin bad++; $display("FAIL dir%0d llbit_we/llbit got=%b%b want=%b%b", i, o.llwe, o.llv, e.llwe, e.llv); end
      if (e.req_cnt > 0) begin
        total++; if ({o.wr, o.be, o.maddr} !== {e.wr, e.be, e.maddr}) begin bad++; $display("FAIL dir%0d wr/be/addr got=%b/%h/%h want=%b/%h/%h", i, o.wr, o.be, o.maddr, e.wr, e.be, e.maddr); end
      end
      if (e.wr) begin
        total++; if (o.mwdata !== e.mwdata) begin bad++; $display("FAIL dir%0d wdata got=%h want=%h", i, o.mwdata, e.mwdata); end
      end
    end
  endtask

  task automatic test_flush_wait();
    stim_t s; obs_t o;
    for (int i = 0; i < 2; i++) begin
      // flush in the 2nd WAIT cycle with ack two cycles later, then flush coincident with ack
      if (i == 0) s = '{4'd5, 32'h300, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 4, 2};
      else        s = '{4'd9, 32'h304, 32'h0, 32'hCAFEF00D, 1'b0, 1'b0, 1'b0, 2, 2};
      run_op(s, o);
      total++; if (o.req_cnt != s.lat) begin bad++; $display("FAIL flush%0d req_cycles got=%0d want=%0d", i, o.req_cnt, s.lat); end
      total++; if (o.done_cnt != 0) begin bad++; $display("FAIL flush%0d done_count got=%0d want=0", i, o.done_cnt); end
      total++; if (o.stall_bad != 0) begin bad++; $display("FAIL flush%0d stall_profile bad_cycles=%0d want=0", i, o.stall_bad); end
      total++; if (o.unstable != 0) begin bad++; $display("FAIL flush%0d bus_stable changes=%0d want=0", i, o.unstable); end
    end
  endtask

  task automatic test_flush_idle_done();
    // flush with a valid op in IDLE: nothing accepted
    @(negedge clk);
    valid_i = 1'b1; op_i = 4'd5; addr_i = 32'h400; flush = 1'b1;
    #1;
    total++; if (stall_o !== 1'b0) begin bad++; $display("FAIL flush_idle stall got=%b want=0", stall_o); end
    @(negedge clk);
    total++; if ({mem_req_o, done_o} !== 2'b00) begin bad++; $display("FAIL flush_idle req/done got=%b want=00", {mem_req_o, done_o}); end
    valid_i = 1'b0; flush = 1'b0;
    // misaligned LW reaches DONE; a flush there suppresses done and adel
    @(negedge clk);
    valid_i = 1'b1; op_i = 4'd5; addr_i = 32'h402;
    @(posedge clk); #1;
    flush = 1'b1; valid_i = 1'b0;
    @(negedge clk);
    total++; if ({done_o, adel_o, ades_o} !== 3'b000) begin bad++; $display("FAIL flush_done done/adel/ades got=%b want=000", {done_o, adel_o, ades_o}); end
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    total++; if ({mem_req_o, done_o, stall_o} !== 3'b000) begin bad++; $display("FAIL flush_done_after got=%b want=000", {mem_req_o, done_o, stall_o}); end
  endtask

  task automatic test_random();
    stim_t s; exp_t e; obs_t o;
    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 9) == 0) s.op = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(11, 15));
      else                           s.op = 4'($urandom_range(1, 10));
      s.addr = $urandom;
      if ($urandom_range(0, 2) != 0) s.addr[1:0] = 2'b00;
      s.wdata = $urandom;
      s.rdata = $urandom;
      if ($urandom_range(0, 4) == 0) llreg = ~llreg;
      s.llbit = llreg;
      s.wb_we = 1'($urandom_range(0, 1));
      s.wb_ll = 1'($urandom_range(0, 1));
      s.lat = $urandom_range(1, 4);
      s.flush_at = ($urandom_range(0, 4) == 0) ? $urandom_range(1, s.lat) : 0;
      e = model(s);
      run_op(s, o);
      if (e.llwe) llreg = e.llv;
      total++; if (o.req_cnt !== e.req_cnt) begin bad++; $display("FAIL rnd%0d op=%0d req_cycles got=%0d want=%0d", i, s.op, o.req_cnt, e.req_cnt); end
      total++; if (o.done_cnt !== e.done_cnt) begin bad++; $display("FAIL rnd%0d op=%0d done_count got=%0d want=%0d", i, s.op, o.done_cnt, e.done_cnt); end
      total++; if (o.stall0 !== e.stall0) begin bad++; $display("FAIL rnd%0d op=%0d accept_stall got=%b want=%b", i, s.op, o.stall0, e.stall0); end
      total++; if (o.stall_bad != 0 || o.unstable != 0) begin bad++; $display("FAIL rnd%0d op=%0d stall/stable bad=%0d/%0d want=0/0", i, s.op, o.stall_bad, o.unstable); end
      total++; if (o.result !== e.result) begin bad++; $display("FAIL rnd%0d op=%0d addr=%h result got=%h want=%h", i, s.op, s.addr, o.result, e.result); end
      total++; if ({o.adel, o.ades, o.llwe, o.llv} !== {e.adel, e.ades, e.llwe, e.llv}) begin bad++; $display("FAIL rnd%0d op=%0d adel/ades/llwe/ll got=%b%b%b%b want=%b%b%b%b", i, s.op, o.adel, o.ades, o.llwe, o.llv, e.adel, e.ades, e.llwe, e.llv); end
      if (e.req_cnt > 0) begin
        total++; if ({o.wr, o.be, o.maddr} !== {e.wr, e.be, e.maddr}) begin bad++; $display("FAIL rnd%0d op=%0d wr/be/addr got=%b/%h/%h want=%b/%h/%h", i, s.op, o.wr, o.be, o.maddr, e.wr, e.be, e.maddr); end
      end
      if (e.wr && e.req_cnt > 0) begin
        total++; if (o.mwdata !== e.mwdata) begin bad++; $display("FAIL rnd%0d op=%0d wdata got=%h want=%h", i, s.op, o.mwdata, e.mwdata); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_flush_wait();
    test_flush_idle_done();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Clock clk; reset rst, synchronous, active-high.
REQ-002 clk  input  1  pipeline clock.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 flush  input  1  pipeline flush from exception logic.
REQ-005 valid_i  input  1  EX stage presents an op this cycle.
REQ-006 op_i  input  4  op code: NONE=0, LB=1, LBU=2, LH=3, LHU=4, LW=5, SB=6, SH=7, SW=8, LL=9, SC=10; others are treated as NONE.
REQ-007 addr_i  input  32  effective address.
REQ-008 wdata_i  input  32  store data (rt).
REQ-009 llbit_i  input  1  current value of the architectural LLbit register.
REQ-010 wb_llbit_we_i, wb_llbit_i  input  1 each  LLbit write pending in WB; used for forwarding.
REQ-011 mem_req_o, mem_wr_o  output  1 each  data-bus request; write qualifier.
REQ-012 mem_be_o  output  4  byte enables.
REQ-013 mem_addr_o, mem_wdata_o  output  32 each  word-aligned address; lane-replicated store data.
REQ-014 mem_ack_i  input  1  bus completion; read data is valid in the same cycle.
REQ-015 mem_rdata_i  input  32  read data.
REQ-016 stall_o  output  1  hold the upstream stages.
REQ-017 done_o  output  1  one-cycle completion pulse.
REQ-018 result_o  output  32  load data, or the SC success flag.
REQ-019 adel_o, ades_o  output  1 each  load or store address-error pulse, coincident with done_o.
REQ-020 llbit_we_o, llbit_o  output  1 each  LLbit register write enable and value.

Function
REQ-021 FSM states are IDLE, WAIT, DRAIN, DONE.
REQ-022 IDLE transitions:
- valid_i with an aligned memory op, or with SC whose effective LLbit is 1: register the request and go to WAIT.
- SC with effective LLbit 0, or a misaligned op: go to DONE with no bus request.
REQ-023 Effective LLbit = wb_llbit_we_i ? wb_llbit_i : llbit_i, sampled in IDLE.
REQ-024 Misalignment rules: half-word ops require addr[0]=0; word ops, LL and SC require addr[1:0]=0. A misaligned load raises adel_o; a misaligned store or SC raises ades_o.
REQ-025 In WAIT, mem_req_o=1 and the address, write, byte-enable and data outputs stay stable until mem_ack_i. Ack leads to DONE and captures mem_rdata_i.
REQ-026 Byte lanes are little-endian:
- Byte ops: be = 1<<addr[1:0].
- Half-word ops: be = 0011 or 1100, selected by addr[1].
- Word ops: be = 1111.
- mem_addr_o = {addr[31:2],2'b00}.
- Store data is replicated across lanes.
REQ-027 Load extension: LB and LH sign-extend the selected lane; LBU and LHU zero-extend it.
REQ-028 DONE lasts one cycle with done_o=1 and returns to IDLE. SC result_o = 1 if the store was performed, else 0.
REQ-029 In DONE, llbit_we_o=1 for LL (llbit_o=1) and for a successful SC (llbit_o=0). A failed SC and all other ops do not write the LLbit register.
REQ-030 stall_o=1 from the cycle an op is accepted through the cycle before DONE. Upstream holds its inputs stable while stall_o=1.
REQ-031 Ops NONE, and cycles with valid_i=0, produce no bus activity and no done_o.
REQ-032 Flush behaviour:
- Flush in IDLE or DONE: the FSM goes to IDLE and outputs in that cycle are suppressed.
- Flush in WAIT: go to DRAIN. DRAIN keeps mem_req_o=1 with stable outputs until mem_ack_i, then returns to IDLE.
- A transaction that completes in DRAIN produces no done_o, no exception and no LLbit write.
REQ-033 Flush coincident with mem_ack_i in WAIT discards the transaction and goes to IDLE.
REQ-034 stall_o=1 in DRAIN.

Reset
REQ-035 During and after rst the block is in IDLE with these outputs 0: mem_req_o, mem_wr_o, mem_be_o, mem_addr_o, mem_wdata_o, stall_o, done_o, result_o, adel_o, ades_o, llbit_we_o, llbit_o.
REQ-036 rst overrides flush and mem_ack_i, including in the middle of a transaction.

Structure
REQ-037 The op-code constants and the FSM state encoding belong in the shared defines package.
REQ-038 Lane select and sign/zero extension is one combinational sub-module, load_align.

Verification
REQ-039 LW to 0x100 with ack after 3 WAIT cycles and rdata 0xDEADBEEF -> mem_req_o high for 3 cycles, be=1111, done_o with result 0xDEADBEEF.
REQ-040 LB to 0x103 with rdata 0x80000000 -> result 0xFFFFFF80; LBU to the same address -> result 0x00000080.
REQ-041 LL to 0x200, then SC to 0x200 with wdata 5 -> LL completes with llbit_we_o=1, llbit_o=1. SC performs a write with be=1111, result 1, llbit_we_o=1, llbit_o=0.
REQ-042 SC with llbit_i=1 while wb_llbit_we_i=1 and wb_llbit_i=0 -> no mem_req_o, done_o with result 0, llbit_we_o=0.
REQ-043 SH to 0x101 -> ades_o with done_o, no bus request; LW to 0x102 -> adel_o.
REQ-044 flush in the 2nd WAIT cycle of an LW, ack 2 cycles later -> mem_req_o held until ack, no done_o, stall_o=1 until the ack cycle, then IDLE.
